mux_scan_reg: RTL and testbench
===============================

# mux_scan_reg

Parametrised, registered N:1 multiplexer with a manual-select mode and an automatic channel-scan mode. Successor to the gate-level 2:1 select cell. It generalises width and input count, registers the output, and adds a scanning sequencer with hold and wrap indication. It sits between groups of same-width sources and a single downstream consumer, such as a monitor bus or a shared output pin.

## Interface
- WIDTH, 8, data bits per channel
- NUM_IN, 4, number of input channels (>= 2)
- SEL_W, $clog2(NUM_IN), width of select and channel index
- DWELL, 4, cycles per channel in scan mode; used only when MUXS_DWELL_EN is defined; >= 1

- CLK  input  1  clock; all state changes on rising edge
- RST  input  1  reset; asynchronous, active-high
- IN_BUS  input  NUM_IN*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- SEL  input  SEL_W  manual-mode channel select
- MODE  input  1  0 = manual, 1 = scan
- HOLD  input  1  1 = freeze all state and outputs
- OUT  output  WIDTH  registered selected data
- OUT_VALID  output  1  OUT holds data from a legal channel
- OUT_CH  output  SEL_W  channel index that OUT was loaded from
- OUT_WRAP  output  1  one-cycle pulse when the scan index wraps to 0

## Operation
- FSM states: MANUAL (reset state) and SCAN. Internal state: scan index ch (SEL_W bits) and dwell counter dc.
- RST asserted: OUT=0, OUT_VALID=0, OUT_CH=0, OUT_WRAP=0, state=MANUAL, ch=0, dc=0. Reset takes effect immediately, including mid-scan.
- HOLD=1 on an edge: nothing changes, except that OUT_WRAP goes to 0. HOLD has priority over MODE.
- MANUAL, MODE=0:
  - If SEL < NUM_IN: OUT←IN_BUS[SEL], OUT_CH←SEL, OUT_VALID←1.
  - If SEL >= NUM_IN: OUT and OUT_CH keep their value, OUT_VALID←0.
- MANUAL, MODE=1: go to SCAN, ch←0, dc←0, OUT←IN_BUS[0], OUT_CH←0, OUT_VALID←1. No wrap pulse on entry.
- SCAN, MODE=1:
  - If dc == DWELL-1: ch←(ch+1) mod NUM_IN and dc←0. Otherwise ch is unchanged and dc←dc+1.
  - OUT←IN_BUS[next ch] and OUT_CH←next ch on every such edge, so data tracks the input live during a dwell.
  - OUT_WRAP←1 exactly on the edge where ch goes from NUM_IN-1 to 0; otherwise 0.
- SCAN, MODE=0: go to MANUAL and apply the MANUAL, MODE=0 rules on the same edge. ch and dc reset to 0.
- Index arithmetic is modulo NUM_IN, not 2^SEL_W. A non-power-of-two NUM_IN must never produce ch >= NUM_IN.

## Timing
- Latency is 1 cycle from a sampled SEL, MODE or IN_BUS to OUT, OUT_CH and OUT_VALID. There is no combinational path from any input to any output.
- OUT_WRAP is registered and high for exactly 1 cycle per wrap.
- On reset release, the first non-HOLD edge applies the MANUAL rules.
- Entering scan: the first edge loads channel 0. Without MUXS_DWELL_EN, channel 1 loads on the next edge.
- Full scan period is NUM_IN×DWELL cycles with the macro, NUM_IN cycles without it. HOLD cycles stretch the period one-for-one.

## Configuration
- MUXS_DWELL_EN defined: the DWELL parameter and counter dc are implemented as described.
- MUXS_DWELL_EN undefined: dc is removed and DWELL is ignored. Behaviour is identical to DWELL=1, so ch advances on every non-HOLD SCAN edge.

## Test plan
- Reset/manual: assert RST mid-stream → all outputs 0 immediately. Release, set SEL=2 with IN_BUS ch2=8'hA5 → after 1 edge OUT=8'hA5, OUT_CH=2, OUT_VALID=1.
- Illegal select: NUM_IN=3, OUT=8'h11 from ch1, then SEL=3 → OUT stays 8'h11, OUT_CH stays 1, OUT_VALID=0. SEL=0 → OUT_VALID returns to 1.
- Scan without macro: NUM_IN=4, channels 8'h10/8'h20/8'h30/8'h40, MODE=1 → OUT sequence 10,20,30,40,10. OUT_WRAP is high only in the cycle OUT=10 the second time.
- Scan with MUXS_DWELL_EN, DWELL=3 → each channel is shown for 3 cycles and the wrap pulse comes every 12 cycles. Changing ch1 data mid-dwell appears on OUT 1 cycle later.
- HOLD: during scan at ch2, HOLD=1 for 5 cycles → OUT, OUT_CH and OUT_VALID are frozen and OUT_WRAP=0. Release → scan resumes at the same ch and dc.
- Mode switch and reset mid-scan: at ch3, MODE=0 with SEL=1 → next edge gives OUT=IN ch1, OUT_CH=1. MODE=1 again → restarts at ch0. RST asserted at ch2 → outputs 0 and state MANUAL.

Source files
------------

// File: rtl/mux_scan_reg_if.sv
// Signal bundle between a channel source/controller and the mux_scan_reg block.
// master drives channel data and controls; slave is the mux itself.
interface mux_scan_reg_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
);
    logic [NUM_IN*WIDTH-1:0] IN_BUS;
    logic [SEL_W-1:0]        SEL;
    logic                    MODE;
    logic                    HOLD;
    logic [WIDTH-1:0]        OUT;
    logic                    OUT_VALID;
    logic [SEL_W-1:0]        OUT_CH;
    logic                    OUT_WRAP;

    modport master (
        output IN_BUS, SEL, MODE, HOLD,
        input  OUT, OUT_VALID, OUT_CH, OUT_WRAP
    );

    modport slave (
        input  IN_BUS, SEL, MODE, HOLD,
        output OUT, OUT_VALID, OUT_CH, OUT_WRAP
    );
endinterface

// File: rtl/mux_scan_reg.sv
// Registered N:1 mux with manual select and an automatic channel scanner.
// Optional per-channel dwell counter enabled by defining MUXS_DWELL_EN.
//
// state  | meaning
// MANUAL | OUT follows IN_BUS[SEL]; illegal SEL keeps OUT and drops OUT_VALID
// SCAN   | OUT follows IN_BUS[ch]; ch steps modulo NUM_IN, pulsing OUT_WRAP at 0
module mux_scan_reg #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN),
    parameter int DWELL  = 4
) (
    input  logic             CLK,
    input  logic             RST,
    mux_scan_reg_if.slave    bus
);

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } state_t;

    localparam logic [SEL_W:0]   NUM_IN_W = NUM_IN[SEL_W:0];
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_IN - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic             out_wrap_q, out_wrap_d;

    logic             adv;
    logic             scan_step;
    logic             seq_clr;
    logic             sel_legal;
    logic [SEL_W-1:0] ch_next;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] next_data;

    // Loop-based pick keeps out-of-range indices from ever slicing past IN_BUS.
    function automatic logic [WIDTH-1:0] pick(
        input logic [NUM_IN*WIDTH-1:0] in_bus,
        input logic [SEL_W-1:0]        idx
    );
        logic [WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (idx == SEL_W'(k)) begin
                r = in_bus[k*WIDTH +: WIDTH];
            end
        end
        return r;
    endfunction

`ifdef MUXS_DWELL_EN
    localparam int              DC_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(DWELL - 1);

    logic [DC_W-1:0] dc_q, dc_d;

    assign adv = (dc_q == DC_LAST);

    always_comb begin
        dc_d = dc_q;
        if (seq_clr) begin
            dc_d = '0;
        end else if (scan_step) begin
            dc_d = adv ? '0 : dc_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dc_q <= '0;
        end else begin
            dc_q <= dc_d;
        end
    end
`else
    wire unused_dwell = (DWELL != 0);

    assign adv = 1'b1;
`endif

    assign sel_legal = ({1'b0, bus.SEL} < NUM_IN_W);
    assign ch_next   = !adv ? ch_q : ((ch_q == LAST_CH) ? '0 : ch_q + 1'b1);
    assign sel_data  = pick(bus.IN_BUS, bus.SEL);
    assign next_data = pick(bus.IN_BUS, ch_next);

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        out_wrap_d  = 1'b0;
        scan_step   = 1'b0;
        seq_clr     = 1'b0;

        if (!bus.HOLD) begin
            if (state_q == SCAN && bus.MODE) begin
                scan_step  = 1'b1;
                ch_d       = ch_next;
                out_d      = next_data;
                out_ch_d   = ch_next;
                out_valid_d = 1'b1;
                out_wrap_d = adv && (ch_q == LAST_CH);
            end else if (state_q == MANUAL && bus.MODE) begin
                // Entry loads channel 0 directly; the first step happens next edge.
                state_d     = SCAN;
                seq_clr     = 1'b1;
                ch_d        = '0;
                out_d       = pick(bus.IN_BUS, '0);
                out_ch_d    = '0;
                out_valid_d = 1'b1;
            end else begin
                state_d = MANUAL;
                seq_clr = 1'b1;
                ch_d    = '0;
                if (sel_legal) begin
                    out_d       = sel_data;
                    out_ch_d    = bus.SEL;
                    out_valid_d = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= MANUAL;
            ch_q        <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_wrap_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_wrap_q  <= out_wrap_d;
        end
    end

    assign bus.OUT       = out_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.OUT_CH    = out_ch_q;
    assign bus.OUT_WRAP  = out_wrap_q;

endmodule

// File: tb/tb_mux_scan_reg.sv
// Directed bench for mux_scan_reg: a 4-input scanner and a 3-input instance
// for illegal-select handling. Dwell expectations follow MUXS_DWELL_EN.
module tb_mux_scan_reg;

`ifdef MUXS_DWELL_EN
    localparam int D = 3;
`else
    localparam int D = 1;
`endif

    logic CLK = 1'b0;
    logic RST;
    int   total = 0;
    int   bad   = 0;
    int   se    = 0;
    int   guard;
    logic [7:0] dat [4];

    always #5 CLK = ~CLK;

    mux_scan_reg_if #(.WIDTH(8), .NUM_IN(4)) if4 ();
    mux_scan_reg_if #(.WIDTH(8), .NUM_IN(3)) if3 ();

    mux_scan_reg #(.WIDTH(8), .NUM_IN(4), .DWELL(3)) u4 (.CLK(CLK), .RST(RST), .bus(if4));
    mux_scan_reg #(.WIDTH(8), .NUM_IN(3))            u3 (.CLK(CLK), .RST(RST), .bus(if3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive4();
        if4.IN_BUS = {dat[3], dat[2], dat[1], dat[0]};
    endtask

    function automatic int exp_ch(input int e);
        return ((e - 1) / D) % 4;
    endfunction

    function automatic logic exp_wrap(input int e);
        return (e > 1) && (((e - 1) % (4 * D)) == 0);
    endfunction

    task automatic scan_tick();
        tick();
        se++;
        chk("scan_out",   {24'h0, if4.OUT},    {24'h0, dat[exp_ch(se)]});
        chk("scan_ch",    {30'h0, if4.OUT_CH}, exp_ch(se));
        chk("scan_valid", {31'h0, if4.OUT_VALID}, 1);
        chk("scan_wrap",  {31'h0, if4.OUT_WRAP},  {31'h0, exp_wrap(se)});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        dat[0] = 8'h01; dat[1] = 8'h02; dat[2] = 8'hA5; dat[3] = 8'h04;
        drive4();
        if4.SEL = 2'd2; if4.MODE = 1'b0; if4.HOLD = 1'b0;
        if3.IN_BUS = {8'h22, 8'h11, 8'h33};
        if3.SEL = 2'd1; if3.MODE = 1'b0; if3.HOLD = 1'b0;

        tick();
        chk("rst_out",   {24'h0, if4.OUT}, 0);
        chk("rst_valid", {31'h0, if4.OUT_VALID}, 0);
        chk("rst_ch",    {30'h0, if4.OUT_CH}, 0);
        chk("rst_wrap",  {31'h0, if4.OUT_WRAP}, 0);
        chk("rst_out3",  {24'h0, if3.OUT}, 0);

        RST = 1'b0;
        tick();
        chk("man_out",    {24'h0, if4.OUT}, 32'hA5);
        chk("man_ch",     {30'h0, if4.OUT_CH}, 2);
        chk("man_valid",  {31'h0, if4.OUT_VALID}, 1);
        chk("man3_out",   {24'h0, if3.OUT}, 32'h11);
        chk("man3_ch",    {30'h0, if3.OUT_CH}, 1);

        #2 RST = 1'b1;
        #1;
        chk("async_rst_out",   {24'h0, if4.OUT}, 0);
        chk("async_rst_valid", {31'h0, if4.OUT_VALID}, 0);
        chk("async_rst_ch",    {30'h0, if4.OUT_CH}, 0);
        chk("async_rst_out3",  {24'h0, if3.OUT}, 0);
        RST = 1'b0;

        tick();
        chk("rel_out",  {24'h0, if4.OUT}, 32'hA5);
        chk("rel_out3", {24'h0, if3.OUT}, 32'h11);

        if3.SEL = 2'd3;
        tick();
        chk("illegal_out",   {24'h0, if3.OUT}, 32'h11);
        chk("illegal_ch",    {30'h0, if3.OUT_CH}, 1);
        chk("illegal_valid", {31'h0, if3.OUT_VALID}, 0);
        if3.SEL = 2'd0;
        tick();
        chk("legal_again_out",   {24'h0, if3.OUT}, 32'h33);
        chk("legal_again_ch",    {30'h0, if3.OUT_CH}, 0);
        chk("legal_again_valid", {31'h0, if3.OUT_VALID}, 1);

        dat[0] = 8'h10; dat[1] = 8'h20; dat[2] = 8'h30; dat[3] = 8'h40;
        drive4();
        if4.MODE = 1'b1;
        se = 0;
        for (int i = 0; i < 8 * D + 1; i++) scan_tick();

        guard = 0;
        while (exp_ch(se + 1) != 2 && guard < 40) begin
            scan_tick();
            guard++;
        end
        scan_tick();
        chk("at_ch2", {30'h0, if4.OUT_CH}, 2);
        if4.HOLD = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_out",   {24'h0, if4.OUT}, 32'h30);
            chk("hold_ch",    {30'h0, if4.OUT_CH}, 2);
            chk("hold_valid", {31'h0, if4.OUT_VALID}, 1);
            chk("hold_wrap",  {31'h0, if4.OUT_WRAP}, 0);
        end
        if4.HOLD = 1'b0;
        for (int i = 0; i < 2 * D; i++) scan_tick();

        guard = 0;
        while (!exp_wrap(se) && guard < 40) begin
            scan_tick();
            guard++;
        end
        chk("wrap_seen", {31'h0, if4.OUT_WRAP}, 1);
        if4.HOLD = 1'b1;
        tick();
        chk("hold_wrap_drop", {31'h0, if4.OUT_WRAP}, 0);
        chk("hold_wrap_out",  {24'h0, if4.OUT}, 32'h10);
        if4.HOLD = 1'b0;
        scan_tick();
        scan_tick();

        guard = 0;
        while (exp_ch(se) != 3 && guard < 40) begin
            scan_tick();
            guard++;
        end
        if4.MODE = 1'b0;
        if4.SEL  = 2'd1;
        tick();
        chk("sw_man_out",  {24'h0, if4.OUT}, 32'h20);
        chk("sw_man_ch",   {30'h0, if4.OUT_CH}, 1);
        chk("sw_man_wrap", {31'h0, if4.OUT_WRAP}, 0);

        if4.MODE = 1'b1;
        se = 0;
        scan_tick();
        guard = 0;
        while (exp_ch(se) != 1 && guard < 40) begin
            scan_tick();
            guard++;
        end
        dat[1] = 8'h2A;
        drive4();
        scan_tick();

        guard = 0;
        while (exp_ch(se) != 2 && guard < 40) begin
            scan_tick();
            guard++;
        end
        #2 RST = 1'b1;
        #1;
        chk("scan_rst_out",   {24'h0, if4.OUT}, 0);
        chk("scan_rst_ch",    {30'h0, if4.OUT_CH}, 0);
        chk("scan_rst_valid", {31'h0, if4.OUT_VALID}, 0);
        RST = 1'b0;
        se = 0;
        scan_tick();
        scan_tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
